// File: rtl/reg_access_ctrl_if.sv
// reg_access_ctrl_if: instruction valid/ready channel into the register-file controller
interface reg_access_ctrl_if #(
   parameter int N = 32,
   parameter int M = 2
);
   logic         insn_valid;
   logic         insn_ready;
   logic [3:0]   insn_op;
   logic [M-1:0] insn_rd;
   logic [M-1:0] insn_rs1;
   logic [M-1:0] insn_rs2;
   logic [N-1:0] insn_imm;
   modport master (
      output insn_valid, insn_op, insn_rd, insn_rs1, insn_rs2, insn_imm,
      input  insn_ready
   );
   modport slave (
      input  insn_valid, insn_op, insn_rd, insn_rs1, insn_rs2, insn_imm,
      output insn_ready
   );
endinterface

// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: 4-cycle read/execute/write-back initiator for a 2R1W register file
module reg_access_ctrl #(
   parameter int N = 32,
   parameter int M = 2
) (
   input  logic                clk,
   input  logic                rst,
   reg_access_ctrl_if.slave    insn,
   input  logic                flush_i,
   output logic [M-1:0]        reg_r1_o,
   output logic [M-1:0]        reg_r2_o,
   output logic [M:0]          reg_w1_o,
   output logic [N-1:0]        reg_w_o,
   input  logic [N-1:0]        reg_v1_i,
   input  logic [N-1:0]        reg_v2_i,
   output logic                done_o,
   output logic [N-1:0]        result_o,
   output logic                zero_o,
   output logic                carry_o,
   output logic                illegal_o
);
   typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
   state_t       state_q, state_d;
   logic [3:0]   op_q, op_d;
   logic [M-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
   logic [N-1:0] imm_q, imm_d, result_q, result_d;
   logic         zero_q, zero_d, carry_q, carry_d;
   logic [N:0]   sum, diff;
   logic [N-1:0] alu;
   logic         alu_c, wr;
   // NOP and the undefined opcodes neither compute nor write back
   assign wr = (op_q != 4'd0) && !op_q[3];
   always_comb begin
      sum   = {1'b0, reg_v1_i} + {1'b0, reg_v2_i};
      diff  = {1'b0, reg_v1_i} - {1'b0, reg_v2_i};
      alu_c = op_q == 4'd1 ? sum[N] : op_q == 4'd2 ? diff[N] : 1'b0;
      case (op_q)
         4'd1:    alu = sum[N-1:0];
         4'd2:    alu = diff[N-1:0];
         4'd3:    alu = reg_v1_i & reg_v2_i;
         4'd4:    alu = reg_v1_i | reg_v2_i;
         4'd5:    alu = reg_v1_i ^ reg_v2_i;
         4'd6:    alu = reg_v1_i;
         4'd7:    alu = imm_q;
         default: alu = result_q;
      endcase
   end
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      rd_d     = rd_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      imm_d    = imm_q;
      result_d = result_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      unique case (state_q)
         IDLE: if (insn.insn_valid) begin
            op_d    = insn.insn_op;
            rd_d    = insn.insn_rd;
            rs1_d   = insn.insn_rs1;
            rs2_d   = insn.insn_rs2;
            imm_d   = insn.insn_imm;
            state_d = READ;
         end
         READ: state_d = flush_i ? IDLE : EXEC;
         EXEC: begin
            state_d = flush_i ? IDLE : WRITE;
            if (!flush_i && wr) begin
               result_d = alu;
               zero_d   = alu == '0;
               carry_d  = alu_c;
            end
         end
         WRITE: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         op_q     <= '0;
         rd_q     <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         imm_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
         carry_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         imm_q    <= imm_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
      end
   end
   assign insn.insn_ready = state_q == IDLE;
   assign reg_r1_o  = rs1_q;
   assign reg_r2_o  = rs2_q;
   assign reg_w1_o  = (state_q == WRITE && wr) ? {1'b0, rd_q} : {1'b1, {M{1'b0}}};
   assign reg_w_o   = result_q;
   assign done_o    = state_q == WRITE;
   assign illegal_o = state_q == WRITE && op_q[3];
   assign result_o  = result_q;
   assign zero_o    = zero_q;
   assign carry_o   = carry_q;
endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb_reg_access_ctrl: scoreboard bench with a behavioural 2R1W register file
module tb_reg_access_ctrl;
   localparam int N = 32;
   localparam int M = 2;
   typedef struct {
      logic [N-1:0] res;
      logic         z, c, ill, wr;
      logic [M-1:0] rd;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic flush = 1'b0;
   logic [M-1:0] reg_r1, reg_r2;
   logic [M:0]   reg_w1;
   logic [N-1:0] reg_w, reg_v1, reg_v2, result;
   logic done, zero, carry, illegal;
   logic [N-1:0] rf [4] = '{default: '0};
   logic [N-1:0] m_rf [4] = '{default: '0};
   logic [N-1:0] m_res = '0;
   logic m_z = 1'b1, m_c = 1'b0;
   exp_t sb[$];
   int n_tests = 0, n_fail = 0;
   always #5 clk = ~clk;
   reg_access_ctrl_if #(.N(N), .M(M)) insn ();
   reg_access_ctrl #(.N(N), .M(M)) dut (
      .clk(clk), .rst(rst), .insn(insn), .flush_i(flush),
      .reg_r1_o(reg_r1), .reg_r2_o(reg_r2), .reg_w1_o(reg_w1), .reg_w_o(reg_w),
      .reg_v1_i(reg_v1), .reg_v2_i(reg_v2), .done_o(done), .result_o(result),
      .zero_o(zero), .carry_o(carry), .illegal_o(illegal)
   );
   always @(posedge clk) begin
      reg_v1 <= rf[reg_r1];
      reg_v2 <= rf[reg_r2];
      if (!reg_w1[M]) rf[reg_w1[M-1:0]] <= reg_w;
   end
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   always @(negedge clk) begin
      if (rst && done) begin
         if (sb.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("result", result, e.res);
            chk("zero", zero, e.z);
            chk("carry", carry, e.c);
            chk("illegal", illegal, e.ill);
            chk("w1", reg_w1, e.wr ? {1'b0, e.rd} : 3'b100);
            if (e.wr) chk("wdata", reg_w, e.res);
         end
      end else chk("quiet", {reg_w1[M], illegal}, 2'b10);
   end
   // fl selects a cycle to raise flush in: 1=READ, 2=EXEC, 3=WRITE, 0=none
   task automatic issue(input logic [3:0] op, input logic [M-1:0] rd, rs1, rs2,
                        input logic [N-1:0] imm, input int fl);
      logic [N:0] s;
      logic [N-1:0] a, b, r;
      logic c, w;
      int lat;
      a = m_rf[rs1];
      b = m_rf[rs2];
      c = 1'b0;
      w = 1'b1;
      case (op)
         4'd1: begin s = {1'b0, a} + {1'b0, b}; r = s[N-1:0]; c = s[N]; end
         4'd2: begin r = a - b; c = a < b; end
         4'd3: r = a & b;
         4'd4: r = a | b;
         4'd5: r = a ^ b;
         4'd6: r = a;
         4'd7: r = imm;
         default: begin r = m_res; c = m_c; w = 1'b0; end
      endcase
      if (fl != 1 && fl != 2) begin
         if (w) begin
            m_res = r;
            m_z = r == '0;
            m_c = c;
            m_rf[rd] = r;
         end
         sb.push_back('{res: m_res, z: m_z, c: m_c, ill: op[3], wr: w, rd: rd});
      end
      @(negedge clk);
      chk("ready", insn.insn_ready, 1);
      insn.insn_valid = 1'b1;
      insn.insn_op = op;
      insn.insn_rd = rd;
      insn.insn_rs1 = rs1;
      insn.insn_rs2 = rs2;
      insn.insn_imm = imm;
      lat = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 1) insn.insn_valid = 1'b0;
         if ((fl == 1 || fl == 2) && i == fl + 1)
            chk("flush_idle", {insn.insn_ready, reg_w1[M], done}, 3'b110);
         if (i == fl) flush = 1'b1;
         else if (i == fl + 1) flush = 1'b0;
         if (done) begin lat = i; break; end
      end
      if (flush) begin
         @(posedge clk);
         #1 flush = 1'b0;
      end
      if (fl == 1 || fl == 2) begin
         chk("flush_no_done", lat, 0);
         chk("flush_result", {result, zero, carry}, {m_res, m_z, m_c});
      end else chk("latency", lat, 3);
   endtask
   task automatic chk_rf();
      @(negedge clk);
      for (int i = 0; i < 4; i++) chk($sformatf("rf%0d", i), rf[i], m_rf[i]);
   endtask
   initial begin
      insn.insn_valid = 1'b0;
      insn.insn_op = '0;
      insn.insn_rd = '0;
      insn.insn_rs1 = '0;
      insn.insn_rs2 = '0;
      insn.insn_imm = '0;
      repeat (2) @(negedge clk);
      chk("rst_outs", {reg_w1, insn.insn_ready, done, illegal, zero, carry}, {3'b100, 5'b10010});
      chk("rst_result", result, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst", {reg_w1, insn.insn_ready, done, reg_r1, reg_r2}, {3'b100, 2'b10, 4'b0});
      issue(4'd7, 2'd1, 2'd0, 2'd0, 32'h1234_5678, 0);
      issue(4'd6, 2'd2, 2'd1, 2'd0, 32'h0, 0);
      chk_rf();
      chk("mov_r2", rf[2], 32'h1234_5678);
      issue(4'd7, 2'd1, 2'd0, 2'd0, 32'hFFFF_FFFF, 0);
      issue(4'd1, 2'd3, 2'd1, 2'd1, 32'h0, 0);
      issue(4'd2, 2'd0, 2'd2, 2'd2, 32'h0, 0);
      issue(4'd7, 2'd1, 2'd0, 2'd0, 32'h1, 0);
      issue(4'd7, 2'd2, 2'd0, 2'd0, 32'h2, 0);
      issue(4'd2, 2'd3, 2'd1, 2'd2, 32'h0, 0);
      chk_rf();
      issue(4'd7, 2'd0, 2'd0, 2'd0, 32'hF0F0_3C3C, 0);
      issue(4'd3, 2'd1, 2'd0, 2'd3, 32'h0, 0);
      issue(4'd4, 2'd2, 2'd0, 2'd2, 32'h0, 0);
      issue(4'd5, 2'd3, 2'd0, 2'd3, 32'h0, 0);
      issue(4'd0, 2'd3, 2'd1, 2'd2, 32'h0, 0);
      issue(4'd9, 2'd2, 2'd1, 2'd1, 32'h0, 0);
      chk_rf();
      issue(4'd1, 2'd1, 2'd3, 2'd3, 32'h0, 2);
      issue(4'd3, 2'd2, 2'd0, 2'd3, 32'h0, 0);
      issue(4'd6, 2'd0, 2'd1, 2'd0, 32'h0, 1);
      issue(4'd4, 2'd0, 2'd1, 2'd3, 32'h0, 3);
      chk_rf();
      @(negedge clk);
      insn.insn_valid = 1'b1;
      insn.insn_op = 4'd7;
      insn.insn_rd = 2'd3;
      insn.insn_imm = 32'hDEAD_BEEF;
      @(negedge clk);
      insn.insn_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("async_rst", {reg_w1, insn.insn_ready, done, zero, carry}, {3'b100, 4'b1010});
      chk("async_rst_result", result, 0);
      m_res = '0;
      m_z = 1'b1;
      m_c = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk_rf();
      issue(4'd1, 2'd0, 2'd1, 2'd2, 32'h0, 0);
      chk_rf();
      chk("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
